// File: rtl/pc_stack_controller.sv
// Program counter and circular hardware return stack for the PIC16F core.
// Acts on one-cycle sequencing strobes from the decoder with fixed priority.
module pc_stack_controller #(
  parameter int unsigned PC_WIDTH     = 13,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter logic [12:0] RESET_VECTOR = 13'h0000,
  parameter logic [12:0] INT_VECTOR   = 13'h0004
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_incr_en,
  input  logic                pc_j_en,
  input  logic                pc_call_en,
  input  logic                pc_ret_en,
  input  logic                pc_int_en,
  input  logic                pcl_wr_en,
  input  logic [7:0]          pcl_wr_data,
  input  logic [10:0]         j_addr,
  input  logic [4:0]          pclath,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] tos,
  output logic [3:0]          stack_depth,
  output logic                stack_overflow,
  output logic                stack_underflow
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH);
  localparam logic [3:0]  FULL = 4'(STACK_DEPTH);

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_INT,
    ACT_RET,
    ACT_CALL,
    ACT_PCL,
    ACT_JMP,
    ACT_INC
  } act_e;

  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]     sp, sp_next, sp_top;
  logic [PC_WIDTH-1:0] pc_next, pc_plus1, push_data, jmp_target;
  logic [3:0]          depth_next;
  logic                push, ovf_set, unf_set;
  act_e                act;

  assign sp_top     = sp - SP_W'(1);
  assign tos        = stack[sp_top];
  assign pc_plus1   = pc_out + PC_WIDTH'(1);
  assign jmp_target = {pclath[4:3], j_addr};

  always_comb begin
    act = ACT_NONE;
    if (pc_int_en)       act = ACT_INT;
    else if (pc_ret_en)  act = ACT_RET;
    else if (pc_call_en) act = ACT_CALL;
    else if (pcl_wr_en)  act = ACT_PCL;
    else if (pc_j_en)    act = ACT_JMP;
    else if (pc_incr_en) act = ACT_INC;
  end

  always_comb begin
    pc_next    = pc_out;
    sp_next    = sp;
    depth_next = stack_depth;
    push       = 1'b0;
    push_data  = '0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    case (act)
      ACT_INT: begin
        push      = 1'b1;
        push_data = pc_out;
        pc_next   = INT_VECTOR;
      end
      ACT_CALL: begin
        push      = 1'b1;
        push_data = pc_plus1;
        pc_next   = jmp_target;
      end
      ACT_RET: begin
        // Underflowing pop still loads whatever the slot holds and wraps sp.
        pc_next = tos;
        sp_next = sp_top;
        if (stack_depth == 4'd0) unf_set = 1'b1;
        else                     depth_next = stack_depth - 4'd1;
      end
      ACT_PCL: pc_next = {pclath, pcl_wr_data};
      ACT_JMP: pc_next = jmp_target;
      ACT_INC: pc_next = pc_plus1;
      default: ;
    endcase
    if (push) begin
      sp_next = sp + SP_W'(1);
      if (stack_depth == FULL) ovf_set = 1'b1;
      else                     depth_next = stack_depth + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out          <= RESET_VECTOR;
      sp              <= '0;
      stack_depth     <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      pc_out      <= pc_next;
      sp          <= sp_next;
      stack_depth <= depth_next;
      if (ovf_set) stack_overflow  <= 1'b1;
      if (unf_set) stack_underflow <= 1'b1;
      if (push)    stack[sp]       <= push_data;
    end
  end

endmodule
